// File: rtl/framebuffer_write_coalescer_pkg.sv
// Shared types and derived constants for the framebuffer write coalescer.
// The FSM state encoding and the pixel-geometry helpers live here.
package framebuffer_write_coalescer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } fbwc_state_t;

  localparam int DEF_STRB_WIDTH = 16;
  localparam int DEF_MASK_WIDTH = 2;
  localparam int PIXEL_COUNT    = DEF_STRB_WIDTH / DEF_MASK_WIDTH;
  localparam int IDX_WIDTH      = $clog2(PIXEL_COUNT);

  function automatic int pixel_count(input int strb_w, input int mask_w);
    return strb_w / mask_w;
  endfunction

  // A single-pixel beat still needs a one-bit slot index.
  function automatic int idx_width(input int strb_w, input int mask_w);
    int pc;
    pc = strb_w / mask_w;
    return (pc > 1) ? $clog2(pc) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_write_coalescer_strobe_gen.sv
// Places a pixel's byte mask at its slot within a memory-beat strobe.
module FramebufferWriterStrobeGen
  import framebuffer_write_coalescer_pkg::*;
#(
  parameter int STRB_WIDTH = 16,
  parameter int MASK_WIDTH = 2,
  localparam int PIX_CNT   = pixel_count(STRB_WIDTH, MASK_WIDTH),
  localparam int IDX_W     = idx_width(STRB_WIDTH, MASK_WIDTH)
) (
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [MASK_WIDTH-1:0] i_mask,
  output logic [STRB_WIDTH-1:0] o_strb
);

  always_comb begin
    o_strb = '0;
    for (int p = 0; p < PIX_CNT; p++) begin
      if (i_idx == IDX_W'(p)) o_strb[p*MASK_WIDTH +: MASK_WIDTH] = i_mask;
    end
  end

endmodule

// File: rtl/framebuffer_write_coalescer.sv
// Merges per-pixel writes into full memory beats; a beat leaves on s_last,
// when fully written, on an address change, on flush or after an idle timeout.
//
// state    | meaning
// ST_IDLE  | no beat open, ready for the first pixel of a beat
// ST_ACCUM | beat open, merging pixels to the same address
// ST_EMIT  | beat presented on m_*, held until m_ready
module framebuffer_write_coalescer
  import framebuffer_write_coalescer_pkg::*;
#(
  parameter int STRB_WIDTH  = 16,
  parameter int MASK_WIDTH  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 15,
  localparam int IDX_W      = idx_width(STRB_WIDTH, MASK_WIDTH)
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ADDR_WIDTH-1:0]   s_addr,
  input  logic [IDX_W-1:0]        s_idx,
  input  logic [MASK_WIDTH*8-1:0] s_data,
  input  logic [MASK_WIDTH-1:0]   s_mask,
  input  logic                    s_last,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [STRB_WIDTH*8-1:0] m_data,
  output logic [STRB_WIDTH-1:0]   m_strb,
  output logic                    idle
);

  localparam int PIX_CNT  = pixel_count(STRB_WIDTH, MASK_WIDTH);
  localparam int PIX_BITS = MASK_WIDTH * 8;
  localparam int DATA_W   = STRB_WIDTH * 8;
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  fbwc_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [CNT_W-1:0]      r_cnt;

  logic [STRB_WIDTH-1:0] w_strb_new, w_base_strb, w_strb_merged;
  logic [DATA_W-1:0]     w_data_slot, w_byte_en, w_base_data, w_data_merged;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_accept, w_addr_hit;

  FramebufferWriterStrobeGen #(
    .STRB_WIDTH (STRB_WIDTH),
    .MASK_WIDTH (MASK_WIDTH)
  ) u_strobe_gen (
    .i_idx  (s_idx),
    .i_mask (s_mask),
    .o_strb (w_strb_new)
  );

  always_comb begin
    w_data_slot = '0;
    for (int p = 0; p < PIX_CNT; p++) begin
      if (s_idx == IDX_W'(p)) w_data_slot[p*PIX_BITS +: PIX_BITS] = s_data;
    end
  end

  always_comb begin
    w_byte_en = '0;
    for (int b = 0; b < STRB_WIDTH; b++) w_byte_en[b*8 +: 8] = {8{w_strb_new[b]}};
  end

  // A fresh beat starts from zero so stale bytes never leak into unstrobed lanes.
  assign w_base_strb   = (r_state == ST_ACCUM) ? r_strb : '0;
  assign w_base_data   = (r_state == ST_ACCUM) ? r_data : '0;
  assign w_strb_merged = w_base_strb | w_strb_new;
  assign w_data_merged = (w_base_data & ~w_byte_en) | (w_data_slot & w_byte_en);
  assign w_addr_hit    = (s_addr == r_addr);
  assign w_cnt_inc     = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (s_last || (&w_strb_merged)) ? ST_EMIT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (s_valid) begin
          if (w_addr_hit) begin
            s_ready     = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = (s_last || (&w_strb_merged)) ? ST_EMIT : ST_ACCUM;
          end else begin
            w_state_nxt = ST_EMIT;
          end
        end else if (flush || (w_cnt_inc == CNT_W'(TIMEOUT))) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        m_valid = 1'b1;
        if (m_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= s_addr;
        r_strb <= w_strb_merged;
        r_data <= w_data_merged;
        r_cnt  <= '0;
      end else if (r_state == ST_ACCUM && !s_valid) begin
        r_cnt <= w_cnt_inc;
      end else if (r_state == ST_EMIT && m_ready) begin
        r_strb <= '0;
        r_cnt  <= '0;
      end
    end
  end

  assign m_addr = r_addr;
  assign m_data = r_data;
  assign m_strb = r_strb;
  assign idle   = (r_state == ST_IDLE);

endmodule

// File: tb/tb_framebuffer_write_coalescer.sv
// Self-checking bench: vector table plus hand-written corner sequences,
// emitted beats compared against a scoreboard queue.
module tb_framebuffer_write_coalescer;

  localparam int TIMEOUT = 15;

  logic         aclk = 1'b0;
  logic         resetn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_addr = '0;
  logic [2:0]   s_idx = '0;
  logic [15:0]  s_data = '0;
  logic [1:0]   s_mask = '0;
  logic         s_last = 1'b0;
  logic         flush = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  m_addr;
  logic [127:0] m_data;
  logic [15:0]  m_strb;
  logic         idle;

  framebuffer_write_coalescer #(
    .STRB_WIDTH (16),
    .MASK_WIDTH (2),
    .ADDR_WIDTH (32),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .aclk    (aclk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_addr  (s_addr),
    .s_idx   (s_idx),
    .s_data  (s_data),
    .s_mask  (s_mask),
    .s_last  (s_last),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .m_strb  (m_strb),
    .idle    (idle)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int beats_seen = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [15:0]  strb;
    logic [127:0] data;
  } beat_t;

  typedef struct {
    logic [31:0]  addr;
    int           idx;
    logic [15:0]  data;
    logic [1:0]   mask;
    logic         last;
    logic         emit;
    logic [15:0]  exp_strb;
    logic [127:0] exp_data;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin : monitor
    beat_t e;
    if (resetn && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got addr %h strb %h want no beat", m_addr, m_strb);
      end else begin
        e = sb.pop_front();
        check("beat_addr", 128'(m_addr), 128'(e.addr));
        check("beat_strb", 128'(m_strb), 128'(e.strb));
        check("beat_data", m_data, e.data);
      end
      beats_seen++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_pixel(input logic [31:0] a, input int idx, input logic [15:0] d,
                            input logic [1:0] m, input logic l);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_addr  = a;
    s_idx   = 3'(idx);
    s_data  = d;
    s_mask  = m;
    s_last  = l;
    #1;
    while (!s_ready && waited < 200) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got s_ready 0 want 1 within 200 cycles");
    end
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(idle && sb.size() == 0) && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check(name, 128'(idle && sb.size() == 0), 128'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] exp_data;
    int           seen_before;
    int           k;

    vecs[0] = '{32'h100, 0, 16'hABCD, 2'b11, 1'b1, 1'b1, 16'h0003, 128'hABCD};
    vecs[1] = '{32'h200, 7, 16'h1234, 2'b10, 1'b1, 1'b1, 16'h8000, 128'h12 << 120};
    vecs[2] = '{32'h300, 5, 16'hBEEF, 2'b01, 1'b1, 1'b1, 16'h0400, 128'hEF << 80};
    vecs[3] = '{32'h400, 3, 16'h5555, 2'b00, 1'b1, 1'b1, 16'h0000, 128'h0};
    vecs[4] = '{32'h500, 0, 16'h0102, 2'b11, 1'b0, 1'b0, 16'h0000, 128'h0};
    vecs[5] = '{32'h500, 1, 16'h0304, 2'b11, 1'b1, 1'b1, 16'h000F, 128'h0304_0102};
    vecs[6] = '{32'h600, 2, 16'hA5FF, 2'b10, 1'b0, 1'b0, 16'h0000, 128'h0};
    vecs[7] = '{32'h600, 2, 16'h113C, 2'b01, 1'b1, 1'b1, 16'h0030, 128'hA53C << 32};

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_idle",    128'(idle),    128'(1));
    check("rst_s_ready", 128'(s_ready), 128'(1));
    check("rst_m_strb",  128'(m_strb),  128'(0));
    check("rst_m_addr",  128'(m_addr),  128'(0));
    check("rst_m_data",  m_data,        128'(0));
    @(negedge aclk);
    resetn = 1'b1;
    @(posedge aclk);
    #1;

    // table-driven single/merged beats
    for (int i = 0; i < 8; i++) begin
      send_pixel(vecs[i].addr, vecs[i].idx, vecs[i].data, vecs[i].mask, vecs[i].last);
      if (vecs[i].emit) begin
        sb.push_back('{addr: vecs[i].addr, strb: vecs[i].exp_strb, data: vecs[i].exp_data});
        check("vec_latency", 128'(m_valid), 128'(1));
      end
    end
    wait_idle("vec_drain");

    // eight pixels, s_last on the final one
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      send_pixel(32'h40, i, 16'hC000 | 16'(i), 2'b11, i == 7);
      exp_data |= 128'(16'hC000 | 16'(i)) << (16 * i);
    end
    sb.push_back('{addr: 32'h40, strb: 16'hFFFF, data: exp_data});
    check("last_latency", 128'(m_valid), 128'(1));
    wait_idle("last_drain");

    // eight pixels without s_last: beat leaves once the strobe is full
    exp_data = '0;
    for (int i = 7; i >= 0; i--) begin
      send_pixel(32'h80, i, 16'h0A00 | 16'(i), 2'b11, 1'b0);
      exp_data |= 128'(16'h0A00 | 16'(i)) << (16 * i);
    end
    sb.push_back('{addr: 32'h80, strb: 16'hFFFF, data: exp_data});
    check("full_latency", 128'(m_valid), 128'(1));
    wait_idle("full_drain");

    // address change forces emission and stalls the new pixel
    send_pixel(32'h40, 2, 16'hAAAA, 2'b11, 1'b0);
    sb.push_back('{addr: 32'h40, strb: 16'h0030, data: 128'hAAAA << 32});
    s_valid = 1'b1; s_addr = 32'h80; s_idx = 3'd3; s_data = 16'hBBBB; s_mask = 2'b11;
    #1;
    check("miss_s_ready", 128'(s_ready), 128'(0));
    @(posedge aclk);
    #1;
    check("miss_m_valid",      128'(m_valid), 128'(1));
    check("miss_emit_s_ready", 128'(s_ready), 128'(0));
    sb.push_back('{addr: 32'h80, strb: 16'h00C0, data: 128'hBBBB << 48});
    send_pixel(32'h80, 3, 16'hBBBB, 2'b11, 1'b0);
    wait_idle("miss_drain");

    // lone pixel leaves after TIMEOUT idle cycles
    send_pixel(32'h1C0, 1, 16'h7777, 2'b11, 1'b0);
    sb.push_back('{addr: 32'h1C0, strb: 16'h000C, data: 128'h7777 << 16});
    k = 0;
    while (!m_valid && k < 40) begin
      @(posedge aclk);
      #1;
      k++;
    end
    check("timeout_cycles", 128'(k), 128'(TIMEOUT));
    wait_idle("timeout_drain");

    // same slot twice: later masked byte wins
    send_pixel(32'h240, 4, 16'h1111, 2'b11, 1'b0);
    send_pixel(32'h240, 4, 16'h2222, 2'b01, 1'b1);
    sb.push_back('{addr: 32'h240, strb: 16'h0300, data: 128'h1122 << 64});
    wait_idle("overwrite_drain");

    // flush while accumulating, then flush in idle
    send_pixel(32'h700, 0, 16'h0F0F, 2'b11, 1'b0);
    sb.push_back('{addr: 32'h700, strb: 16'h0003, data: 128'h0F0F});
    flush = 1'b1;
    @(posedge aclk);
    #1;
    flush = 1'b0;
    check("flush_m_valid", 128'(m_valid), 128'(1));
    wait_idle("flush_drain");
    flush = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    flush = 1'b0;
    check("idle_flush_idle",    128'(idle),    128'(1));
    check("idle_flush_m_valid", 128'(m_valid), 128'(0));

    // back-pressure: beat held stable for 10 cycles
    m_ready = 1'b0;
    send_pixel(32'h280, 6, 16'hCAFE, 2'b11, 1'b1);
    sb.push_back('{addr: 32'h280, strb: 16'h3000, data: 128'hCAFE << 96});
    for (int c = 0; c < 10; c++) begin
      @(posedge aclk);
      #1;
      check("hold_m_valid", 128'(m_valid), 128'(1));
      check("hold_m_addr",  128'(m_addr),  128'(32'h280));
      check("hold_m_strb",  128'(m_strb),  128'(16'h3000));
      check("hold_m_data",  m_data,        128'hCAFE << 96);
      check("hold_s_ready", 128'(s_ready), 128'(0));
    end
    m_ready = 1'b1;
    wait_idle("hold_drain");

    // reset while accumulating discards the beat
    send_pixel(32'h300, 0, 16'h9999, 2'b11, 1'b0);
    check("pre_rst_idle", 128'(idle), 128'(0));
    seen_before = beats_seen;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_m_valid", 128'(m_valid), 128'(0));
    check("mid_rst_idle",    128'(idle),    128'(1));
    check("mid_rst_s_ready", 128'(s_ready), 128'(1));
    check("mid_rst_m_strb",  128'(m_strb),  128'(0));
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    repeat (30) @(posedge aclk);
    #1;
    check("post_rst_no_beat", 128'(beats_seen), 128'(seen_before));
    check("post_rst_idle",    128'(idle),       128'(1));

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_write_coalescer.md
FRAMEBUFFER_WRITE_COALESCER -- requirements
Module: framebuffer_write_coalescer

Interface
REQ-001 SHALL have parameter STRB_WIDTH, default 16, bytes per memory beat.
REQ-002 SHALL have parameter MASK_WIDTH, default 2, bytes per pixel; PIXEL_COUNT = STRB_WIDTH/MASK_WIDTH, IDX_WIDTH = clog2(PIXEL_COUNT).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, beat address width.
REQ-004 SHALL have parameter TIMEOUT, default 15, idle cycles before a partial beat is flushed.
REQ-005 aclk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 s_valid / s_ready  input / output  1 / 1  pixel write handshake.
REQ-008 s_addr  input  ADDR_WIDTH  beat-aligned address of the pixel.
REQ-009 s_idx  input  IDX_WIDTH  pixel slot within the beat.
REQ-010 s_data  input  MASK_WIDTH*8  pixel value.
REQ-011 s_mask  input  MASK_WIDTH  per-byte write enable of the pixel.
REQ-012 s_last  input  1  flush after merging this pixel.
REQ-013 flush  input  1  level request to emit any pending beat.
REQ-014 m_valid / m_ready  output / input  1 / 1  beat handshake.
REQ-015 m_addr, m_data, m_strb  output  ADDR_WIDTH, STRB_WIDTH*8, STRB_WIDTH  beat address, data, byte strobe.
REQ-016 idle  output  1  high when no beat is pending or in emission.

Function
REQ-017 SHALL implement states IDLE, ACCUM, EMIT.
REQ-018 IDLE: s_ready=1; accepted pixel loads m_addr=s_addr, strb=mask shifted to slot s_idx*MASK_WIDTH, data slot s_idx=s_data (masked bytes only), others zero; -> ACCUM, or -> EMIT if s_last or strb all-ones.
REQ-019 ACCUM, s_valid with s_addr==m_addr: s_ready=1; merge strb |= new strobe; masked bytes overwritten (later pixel wins); timeout counter cleared; -> EMIT if s_last or merged strb all-ones.
REQ-020 ACCUM, s_valid with s_addr!=m_addr: s_ready=0, pixel not consumed; -> EMIT next cycle.
REQ-021 ACCUM, no s_valid: counter increments; at counter==TIMEOUT or flush=1 -> EMIT.
REQ-022 EMIT: m_valid=1, s_ready=0; m_addr/m_data/m_strb stable until m_ready; on handshake -> IDLE, strb and counter cleared.
REQ-023 A pixel with s_mask=0 SHALL be accepted and SHALL NOT change data or strb; in IDLE it still opens a beat (strb=0) which is emitted with zero strobe only if s_last/flush/timeout.
REQ-024 Latency: accepted pixel to m_valid SHALL be exactly 1 cycle when it completes the beat (s_last or full).
REQ-025 Counter SHALL saturate at TIMEOUT; width clog2(TIMEOUT+1).
REQ-026 flush in IDLE SHALL have no effect; idle=1 iff state==IDLE.
REQ-027 m_valid SHALL NOT deassert without m_ready handshake.
REQ-028 No combinational path from m_ready to s_ready.

Reset
REQ-029 On resetn=0, asynchronously: state=IDLE, m_valid=0, m_strb=0, m_data=0, m_addr=0, counter=0, s_ready=1 combinationally from IDLE, idle=1.
REQ-030 Reset mid-ACCUM or mid-EMIT SHALL discard the pending beat; no beat emitted afterwards.

Structure
REQ-031 State enumeration and derived constants (PIXEL_COUNT, IDX_WIDTH) SHALL live in a shared package.
REQ-032 Per-pixel strobe placement SHALL use one FramebufferWriterStrobeGen instance (STRB_WIDTH, MASK_WIDTH); data placement by the same slot index.

Verification
REQ-033 Pixels idx 0..7 mask 2'b11 addr 0x40, s_last on idx 7 -> one beat addr 0x40, strb 0xFFFF, m_valid 1 cycle after last accept.
REQ-034 Pixel idx 2 addr 0x40 then idx 3 addr 0x80 -> beat addr 0x40 strb 0x0030 with s_ready=0 during emit; then beat 0x80 strb 0x00C0 after timeout.
REQ-035 Single pixel idx 1, no further input -> beat strb 0x000C emitted after TIMEOUT (15) idle cycles.
REQ-036 Same idx 4 written twice (data 0x1111 mask 11, then 0x2222 mask 01) -> m_data slot 4 = 0x1122, strb 0x0300.
REQ-037 m_ready held 0 for 10 cycles in EMIT -> m_valid/m_addr/m_data/m_strb stable, s_ready=0 throughout.
REQ-038 resetn pulsed low in ACCUM -> m_valid=0, idle=1 immediately; no beat emitted.
